// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Purpose  : Byte-wide RAM plus memory-mapped IO (TX/RX FIFOs, status/halt)
//            behind the memctrl bus. Optional build macro RESP_CYCLE_CNT_EN
//            adds a 32-bit cycle counter readable at 0x30008..0x3000B.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_end,
  output logic        tx_overflow
);

  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int RX_PW = $clog2(RX_DEPTH);

  localparam logic [TX_PW:0] TX_FULL_CNT = (TX_PW+1)'(TX_DEPTH);
  localparam logic [TX_PW:0] TX_THRESH   = (TX_PW+1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [TX_PW:0] TX_CNT_ONE  = (TX_PW+1)'(1);
  localparam logic [TX_PW-1:0] TX_PTR_ONE = TX_PW'(1);
  localparam logic [RX_PW:0] RX_FULL_CNT = (RX_PW+1)'(RX_DEPTH);
  localparam logic [RX_PW:0] RX_CNT_ONE  = (RX_PW+1)'(1);
  localparam logic [RX_PW-1:0] RX_PTR_ONE = RX_PW'(1);

  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;
  localparam logic [31:0] IO_CYC0 = 32'h0003_0008;
  localparam logic [31:0] IO_CYC1 = 32'h0003_0009;
  localparam logic [31:0] IO_CYC2 = 32'h0003_000A;
  localparam logic [31:0] IO_CYC3 = 32'h0003_000B;

  // ---------------------------------------------------------------- decode
  logic              is_io;
  logic              sel_data;
  logic              sel_stat;
  logic [RAM_AW-1:0] ram_idx;

  assign is_io    = (mem_a[17:16] == 2'b11);
  assign sel_data = (mem_a == IO_DATA);
  assign sel_stat = (mem_a == IO_STAT);
  assign ram_idx  = mem_a[RAM_AW-1:0];

  // ---------------------------------------------------------------- RAM
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] ram_q;

  // Read data lands in its own register so the array maps onto block RAM;
  // the output mux below selects it via a registered flag.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !is_io) begin
      if (mem_wr) begin
        ram[ram_idx] <= mem_dout;
      end else begin
        ram_q <= ram[ram_idx];
      end
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_PW-1:0] tx_rd_ptr;
  logic [TX_PW-1:0] tx_wr_ptr;
  logic [TX_PW:0]   tx_count;
  logic [TX_PW:0]   tx_count_next;
  logic             tx_full;
  logic             tx_push;
  logic             tx_drop;
  logic             tx_pop;

  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_push  = rdy && mem_wr && sel_data && !tx_full;
  assign tx_drop  = rdy && mem_wr && sel_data && tx_full;
  assign tx_valid = (tx_count != '0);
  assign tx_pop   = rdy && tx_valid && tx_ready;
  assign tx_data  = tx_mem[tx_rd_ptr];

  always_comb begin
    tx_count_next = tx_count;
    if (tx_push && !tx_pop) begin
      tx_count_next = tx_count + TX_CNT_ONE;
    end else if (!tx_push && tx_pop) begin
      tx_count_next = tx_count - TX_CNT_ONE;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_PW-1:0] rx_rd_ptr;
  logic [RX_PW-1:0] rx_wr_ptr;
  logic [RX_PW:0]   rx_count;
  logic             rx_empty;
  logic             rx_push;
  logic             rx_pop;

  assign rx_empty = (rx_count == '0);
  assign rx_ready = (rx_count != RX_FULL_CNT);
  assign rx_push  = rdy && rx_valid && rx_ready;
  assign rx_pop   = rdy && !mem_wr && sel_data && !rx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= mem_dout;
    end
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_data;
    end
  end

  // ---------------------------------------------------------------- cycle counter
`ifdef RESP_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;
  logic [23:0] cyc_shadow;

  // Upper bytes are frozen when byte 0 is read so a 4-byte read is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt    <= '0;
      cyc_shadow <= '0;
    end else if (rdy) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (!mem_wr && (mem_a == IO_CYC0)) begin
        cyc_shadow <= cyc_cnt[31:8];
      end
    end
  end
`endif

  // ---------------------------------------------------------------- IO read mux
  logic [7:0] io_rd_data;

  always_comb begin
    io_rd_data = 8'h00;
    case (mem_a)
      IO_DATA: io_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      IO_STAT: io_rd_data = {5'b0, tx_overflow, !rx_empty, tx_full};
`ifdef RESP_CYCLE_CNT_EN
      IO_CYC0: io_rd_data = cyc_cnt[7:0];
      IO_CYC1: io_rd_data = cyc_shadow[7:0];
      IO_CYC2: io_rd_data = cyc_shadow[15:8];
      IO_CYC3: io_rd_data = cyc_shadow[23:16];
`else
      IO_CYC0, IO_CYC1, IO_CYC2, IO_CYC3: io_rd_data = 8'h00;
`endif
      default: io_rd_data = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------- control state
  logic       rd_ram_sel;
  logic [7:0] io_q;

  assign mem_din = rd_ram_sel ? ram_q : io_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ram_sel     <= 1'b0;
      io_q           <= 8'h00;
      tx_rd_ptr      <= '0;
      tx_wr_ptr      <= '0;
      tx_count       <= '0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
      rx_rd_ptr      <= '0;
      rx_wr_ptr      <= '0;
      rx_count       <= '0;
      sim_end        <= 1'b0;
    end else begin
      sim_end <= rdy && mem_wr && sel_stat;
      if (rdy) begin
        rd_ram_sel <= !mem_wr && !is_io;
        io_q       <= mem_wr ? 8'h00 : io_rd_data;

        tx_count       <= tx_count_next;
        // Registered from next-state count: the margin covers memctrl's reaction delay.
        io_buffer_full <= (tx_count_next >= TX_THRESH);
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
        if (tx_drop) tx_overflow <= 1'b1;

        if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
        if (rx_push && !rx_pop) begin
          rx_count <= rx_count + RX_CNT_ONE;
        end else if (!rx_push && rx_pop) begin
          rx_count <= rx_count - RX_CNT_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// Testbench for mem_io_responder: directed scenarios followed by randomized
// bus/host traffic, all checked every cycle against a queue-based model.
module tb_mem_io_responder;

  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;
  localparam logic [31:0] IO_CYC0 = 32'h0003_0008;

  logic        clk = 1'b0;
  logic        rst, rdy, mem_wr, tx_ready, rx_valid;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, rx_data;
  logic [7:0]  mem_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_ready, sim_end, tx_overflow;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .sim_end(sim_end), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------ reference model
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  ram_m [int unsigned];
  logic [7:0]  exp_din;
  bit          din_known;
  bit          exp_full, exp_ovf, exp_sim_end;
  logic [31:0] cyc;
  logic [23:0] shadow;

  task automatic model_step();
    bit          io, tx_pop_now, tx_was_full, rx_had, rx_can;
    int unsigned idx;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      exp_din = 8'h00; din_known = 1;
      exp_full = 0; exp_ovf = 0; exp_sim_end = 0;
      cyc = 0; shadow = 0;
    end else if (rdy) begin
      io          = (mem_a[17:16] == 2'b11);
      idx         = mem_a & 32'h1FFFF;
      tx_pop_now  = (tx_q.size() != 0) && tx_ready;
      tx_was_full = (tx_q.size() == 16);
      rx_had      = (rx_q.size() != 0);
      rx_can      = (rx_q.size() != 16);
      exp_sim_end = 0;
      din_known   = 1;
      if (tx_pop_now) void'(tx_q.pop_front());
      if (mem_wr) begin
        exp_din = 8'h00;
        if (!io) ram_m[idx] = mem_dout;
        else if (mem_a == IO_DATA) begin
          if (tx_was_full) exp_ovf = 1;
          else tx_q.push_back(mem_dout);
        end else if (mem_a == IO_STAT) exp_sim_end = 1;
      end else begin
        exp_din = 8'h00;
        if (!io) begin
          if (ram_m.exists(idx)) exp_din = ram_m[idx];
          else din_known = 0;
        end else if (mem_a == IO_DATA) begin
          if (rx_had) exp_din = rx_q.pop_front();
        end else if (mem_a == IO_STAT) begin
          exp_din = {5'b0, exp_ovf, rx_had, tx_was_full};
        end
`ifdef RESP_CYCLE_CNT_EN
        else if (mem_a == IO_CYC0) begin
          exp_din = cyc[7:0];
          shadow  = cyc[31:8];
        end
        else if (mem_a == IO_CYC0 + 1) exp_din = shadow[7:0];
        else if (mem_a == IO_CYC0 + 2) exp_din = shadow[15:8];
        else if (mem_a == IO_CYC0 + 3) exp_din = shadow[23:16];
`endif
      end
      if (rx_valid && rx_can) rx_q.push_back(rx_data);
      exp_full = (tx_q.size() >= 14);
      cyc = cyc + 1;
    end else begin
      exp_sim_end = 0;
    end
  endtask

  task automatic check_outputs();
    if (din_known) check_val("mem_din", mem_din, exp_din);
    check_val("io_buffer_full", io_buffer_full, exp_full);
    check_val("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check_val("tx_data", tx_data, tx_q[0]);
    check_val("rx_ready", rx_ready, rx_q.size() != 16);
    check_val("sim_end", sim_end, exp_sim_end);
    check_val("tx_overflow", tx_overflow, exp_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    mem_a = a; mem_wr = w; mem_dout = d;
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    logic [31:0] word, c_exp, got;
    int          op;
    rst = 1; rdy = 1; mem_a = 0; mem_wr = 0; mem_dout = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    tick(); tick();
    rst = 0;

    // RAM byte and 4-byte LSB-first word
    bus(32'h100, 1, 8'hA5); tick();
    bus(32'h100, 0, 8'h00); tick();
    check_val("ram_rd_a5", mem_din, 8'hA5);
    word = 32'h12345678;
    for (int i = 0; i < 4; i++) begin bus(32'h200 + i, 1, word[8*i +: 8]); tick(); end
    for (int i = 0; i < 4; i++) begin
      bus(32'h200 + i, 0, 0); tick();
      check_val("ram_word", mem_din, word[8*i +: 8]);
    end

    // TX fill, near-full flag, overflow, drain
    for (int i = 0; i < 14; i++) begin bus(IO_DATA, 1, 8'h10 + 8'(i)); tick(); end
    check_val("full_after14", io_buffer_full, 1);
    for (int i = 14; i < 17; i++) begin bus(IO_DATA, 1, 8'h10 + 8'(i)); tick(); end
    check_val("ovf_after17", tx_overflow, 1);
    bus(32'h100, 0, 0);
    tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check_val("drain_order", tx_data, 8'h10 + 8'(i));
      tick();
    end
    check_val("drained_empty", tx_valid, 0);
    tx_ready = 0;

    // RX path and status bit1
    rx_valid = 1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 0;
    bus(IO_STAT, 0, 0); tick(); check_val("stat_rx_set", mem_din, 8'h06);
    bus(IO_DATA, 0, 0); tick(); check_val("rx_rd0", mem_din, 8'h41);
    bus(IO_DATA, 0, 0); tick(); check_val("rx_rd1", mem_din, 8'h42);
    bus(IO_STAT, 0, 0); tick(); check_val("stat_rx_clr", mem_din, 8'h04);
    bus(IO_DATA, 0, 0); tick(); check_val("rx_rd_empty", mem_din, 8'h00);

    // Simultaneous TX push and host pop at count 5
    for (int i = 0; i < 5; i++) begin bus(IO_DATA, 1, 8'h50 + 8'(i)); tick(); end
    tx_ready = 1; bus(IO_DATA, 1, 8'h55); tick();
    check_val("simul_head", tx_data, 8'h51);
    bus(32'h100, 0, 0);
    for (int i = 1; i < 6; i++) begin
      check_val("simul_order", tx_data, 8'h50 + 8'(i));
      tick();
    end
    tx_ready = 0;

    // rdy=0 freeze, then reset with bytes queued
    for (int i = 0; i < 3; i++) begin bus(IO_DATA, 1, 8'h60 + 8'(i)); tick(); end
    rx_valid = 1; rx_data = 8'h77; bus(32'h100, 0, 0); tick();
    rdy = 0; tx_ready = 1; bus(IO_DATA, 0, 0); tick(); tick();
    check_val("frozen_txv", tx_valid, 1);
    rdy = 1; tx_ready = 0; rx_valid = 0; bus(32'h100, 0, 0);
    rst = 1; tick(); rst = 0;
    check_val("rst_txv", tx_valid, 0);
    check_val("rst_full", io_buffer_full, 0);

    // Halt pulse
    bus(IO_STAT, 1, 0); tick(); check_val("sim_end_hi", sim_end, 1);
    bus(32'h100, 0, 0); tick(); check_val("sim_end_lo", sim_end, 0);

    // Coherent cycle counter read
    c_exp = cyc;
    got = 0;
    for (int i = 0; i < 4; i++) begin
      bus(IO_CYC0 + i, 0, 0); tick();
      got[8*i +: 8] = mem_din;
    end
`ifdef RESP_CYCLE_CNT_EN
    check_val("cyc_word", got, c_exp);
`else
    check_val("cyc_word", got, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 249) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = $urandom_range(0, 1);
      rx_data  = 8'($urandom);
      op       = $urandom_range(0, 9);
      case (op)
        0, 1: bus({14'h0, 2'($urandom_range(0, 2)), 10'h0, 6'($urandom_range(0, 63))}, 1, 8'($urandom));
        2, 3: bus({14'h0, 2'($urandom_range(0, 2)), 10'h0, 6'($urandom_range(0, 63))}, 0, 0);
        4, 5: bus(IO_DATA, 1, 8'($urandom));
        6:    bus(IO_DATA, 0, 0);
        7:    bus(IO_STAT, 0, 0);
        8:    bus(IO_CYC0 + 32'($urandom_range(0, 3)), 0, 0);
        default: begin
          case ($urandom_range(0, 3))
            0:       bus(IO_STAT, 1, 0);
            1:       bus(32'h0003_000C, 1, 8'($urandom));
            2:       bus(32'h0003_0001, 0, 0);
            default: bus(32'h0003_FFF0, 0, 0);
          endcase
        end
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the byte-wide memctrl bus (address, read/write, byte out, byte in), acting as RAM plus memory-mapped IO.
- Serves byte reads with fixed 1-cycle latency and byte writes into an internal RAM array.
- Maps an IO window onto a TX FIFO (CPU output bytes), an RX FIFO (host input bytes) and a status/halt register.
- Generates io_buffer_full back to memctrl and drains bytes to a host-side streaming interface.

Parameters:
- RAM_AW, 17, RAM index width; array holds 2^RAM_AW bytes, indexed by mem_a[RAM_AW-1:0].
- TX_DEPTH, 16, TX FIFO entries; power of two, at least 4.
- RX_DEPTH, 16, RX FIFO entries; power of two.
- FULL_MARGIN, 2, io_buffer_full asserts when tx_count >= TX_DEPTH-FULL_MARGIN.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; 0 freezes all state
- mem_a  in  32  byte address from memctrl
- mem_wr  in  1  1=write, 0=read
- mem_dout  in  8  write byte from memctrl
- mem_din  out  8  read byte to memctrl, registered
- io_buffer_full  out  1  TX FIFO near full, registered
- tx_valid  out  1  TX FIFO non-empty
- tx_data  out  8  TX FIFO head byte
- tx_ready  in  1  host accepts tx_data
- rx_valid  in  1  host offers rx_data
- rx_data  in  8  host input byte
- rx_ready  out  1  RX FIFO not full
- sim_end  out  1  one-cycle halt pulse
- tx_overflow  out  1  sticky: TX push dropped

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On rst, mem_din=0, both FIFOs empty (pointers and counts 0), io_buffer_full=0, tx_valid=0, sim_end=0, tx_overflow=0, rx_ready=1. RAM contents are not reset.
- Reset mid-operation discards all FIFO contents.
- rdy=0: no state change. mem_din and FIFOs hold. Host-side handshakes are ignored (tx_ready, rx_valid cause no pop/push).
- Decode: IO when mem_a[17:16]==2'b11; otherwise RAM.
  - IO_DATA=0x30000
  - IO_STAT=0x30004
  - IO_CYC=0x30008..0x3000B
  - Any other IO address reads 0; writes to it are ignored.
- RAM read (mem_wr=0): mem_din <= ram[mem_a[RAM_AW-1:0]] at the posedge. Data is valid the cycle after the address is presented.
- RAM write (mem_wr=1): ram[idx] <= mem_dout at the posedge; mem_din <= 0.
- No read-during-write forwarding is needed; the bus carries one access per cycle.
- IO_DATA write: push mem_dout into TX. If TX is full, drop the byte and set tx_overflow.
- IO_DATA read:
  - Every rdy cycle with mem_wr=0 and mem_a==IO_DATA pops RX; mem_din <= head.
  - If RX is empty, mem_din <= 0 and nothing is popped.
  - memctrl presents IO_DATA for exactly one cycle per intended read.
- IO_STAT read: mem_din <= {5'b0, tx_overflow, rx_count!=0, tx_count==TX_DEPTH}.
- IO_STAT write: sim_end pulses 1 the next cycle; this is the only source of sim_end.
- TX drain: tx_valid = tx_count!=0; tx_data = head (combinational from FIFO). Pop on tx_valid&&tx_ready.
- RX fill: rx_ready = rx_count!=RX_DEPTH. Push on rx_valid&&rx_ready.
- Simultaneous push and pop on the same FIFO in one cycle: both occur and the count is unchanged.
- A pop on an empty FIFO and a push on a full FIFO are impossible through the handshake, except the CPU TX overflow case above.
- FIFO pointers wrap modulo depth.
- io_buffer_full is registered from the next-state tx_count (tx_count_next >= TX_DEPTH-FULL_MARGIN). The margin absorbs memctrl's 1-cycle reaction delay.

Optional Feature:
- RESP_CYCLE_CNT_EN defined:
  - A 32-bit free-running counter increments every rdy cycle and resets to 0.
  - Reading 0x30008 returns counter[7:0] and snapshots counter[31:8] into a shadow register.
  - Reads of 0x30009/0x3000A/0x3000B return shadow bytes 1/2/3, giving a coherent 4-byte LSB-first read.
- RESP_CYCLE_CNT_EN undefined: IO_CYC reads return 0; no counter logic is present.

Test Plan:
- RAM write/read: write 0xA5 to 0x00100 (mem_wr=1, mem_dout=0xA5), then read 0x00100 -> mem_din=0xA5 exactly one cycle after the address is presented. A 4-byte LSB-first read of a word preloaded with 0x12345678 at 0x00200 returns 0x78,0x56,0x34,0x12.
- TX flow: tx_ready=0, 14 writes to 0x30000 -> io_buffer_full=1 the cycle after the 14th write.
  - 2 more writes -> tx_count=16.
  - 17th write -> dropped, tx_overflow=1.
  - Raise tx_ready -> 16 bytes drained in order, tx_valid=0 afterwards.
- RX: host pushes 0x41, 0x42. Read 0x30000 three times -> mem_din 0x41, 0x42, 0x00. Status read in between shows bit1 set, then clear.
- Simultaneous: a TX push and host pop in the same cycle with tx_count=5 -> tx_count stays 5, byte order preserved.
- rdy/reset: rdy=0 while a host handshake is asserted -> no FIFO change and mem_din held. rst asserted with 3 bytes queued -> tx_valid=0 and io_buffer_full=0 next cycle.
- Halt/counter: write 0x30004 -> sim_end=1 for exactly one cycle. With RESP_CYCLE_CNT_EN, reading 0x30008..0x3000B yields a value matching the cycle of the 0x30008 read.
